// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for a single-ported unified memory
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    input  logic              ldr_lock,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  lat_cnt;
    logic        last;      // 1: loader was granted most recently
    logic        owner;     // 1: loader owns the current access
    logic        cmd_we;
    logic        grant_cpu;
    logic        grant_ldr;

    // The lock only vetoes the CPU; round-robin decides simultaneous requests.
    always_comb begin
        grant_cpu = 1'b0;
        grant_ldr = 1'b0;
        if (ldr_lock) begin
            grant_ldr = ldr_req;
        end else if (cpu_req && ldr_req) begin
            grant_cpu = last;
            grant_ldr = ~last;
        end else begin
            grant_cpu = cpu_req;
            grant_ldr = ldr_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lat_cnt   <= 4'd0;
            last      <= 1'b1;
            owner     <= 1'b0;
            cmd_we    <= 1'b0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_cpu || grant_ldr) begin
                        owner     <= grant_ldr;
                        last      <= grant_ldr;
                        cmd_we    <= grant_ldr ? ldr_we : cpu_we;
                        mem_we    <= grant_ldr ? ldr_we : cpu_we;
                        mem_addr  <= grant_ldr ? ldr_addr : cpu_addr;
                        mem_wdata <= grant_ldr ? ldr_wdata : cpu_wdata;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    lat_cnt <= 4'(MEM_LAT - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    // Writes wait out the same latency so every access takes equal time.
                    if (lat_cnt == 4'd0) begin
                        if (!cmd_we) begin
                            rdata <= mem_rdata;
                        end
                        cpu_ack <= ~owner;
                        ldr_ack <= owner;
                        state   <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int P   = LAT + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
    logic [AW-1:0] cpu_addr = '0, ldr_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, ldr_wdata = '0, mem_rdata = '0;
    logic          cpu_ack, ldr_ack, mem_en, mem_we, busy;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    logic          s_cpu_req = 1'b0;
    logic [DW-1:0] s_mem_rdata = '0;
    logic          s_cpu_ack, s_ldr_ack, s_mem_en, s_mem_we, s_busy;
    logic [DW-1:0] s_rdata, s_mem_wdata;
    logic [AW-1:0] s_mem_addr;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .reset(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
        .ldr_lock(ldr_lock), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_lat1 (
        .clk(clk), .reset(rst),
        .cpu_req(s_cpu_req), .cpu_we(1'b0), .cpu_addr(32'h7), .cpu_wdata(32'h0), .cpu_ack(s_cpu_ack),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0), .ldr_ack(s_ldr_ack),
        .ldr_lock(1'b0), .rdata(s_rdata),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rdata(s_mem_rdata), .busy(s_busy)
    );

    task automatic chk1(input string name, input logic got, input logic exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference model: t_m counts cycles since the grant (0 = idle), outputs follow from it.
    int            t_m     = 0;
    logic          m_last  = 1'b1;
    logic          m_owner = 1'b0;
    logic          m_we    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0, m_rval = '0, m_rdata = '0;
    logic [DW-1:0] mdl_mem [32];
    logic [DW-1:0] drv_mem [32];
    int            rd_cnt  = 0;
    logic [DW-1:0] rd_val  = '0;

    always @(posedge clk) begin : model
        int g;
        g = -1;
        if (rst) begin
            t_m     = 0;
            m_last  = 1'b1;
            m_rdata = '0;
        end else if (t_m == 0) begin
            if (ldr_lock) begin
                if (ldr_req) g = 1;
            end else if (cpu_req && ldr_req) begin
                g = m_last ? 0 : 1;
            end else if (cpu_req) begin
                g = 0;
            end else if (ldr_req) begin
                g = 1;
            end
            if (g >= 0) begin
                t_m     = 1;
                m_owner = (g == 1);
                m_last  = m_owner;
                m_we    = m_owner ? ldr_we : cpu_we;
                m_addr  = m_owner ? ldr_addr : cpu_addr;
                m_wdata = m_owner ? ldr_wdata : cpu_wdata;
                if (m_we) mdl_mem[m_addr[4:0]] = m_wdata;
                else      m_rval = mdl_mem[m_addr[4:0]];
            end
        end else if (t_m == LAT + 2) begin
            t_m = 0;
        end else begin
            t_m++;
            if (t_m == LAT + 2 && !m_we) m_rdata = m_rval;
        end
    end

    // Compare against the model, then act as the memory: data is driven only in the issue+LAT cycle.
    always @(negedge clk) begin : compare
        logic data_now;
        chk1("busy", busy, t_m != 0);
        chk1("mem_en", mem_en, t_m == 1);
        chk1("cpu_ack", cpu_ack, (t_m == LAT + 2) && !m_owner);
        chk1("ldr_ack", ldr_ack, (t_m == LAT + 2) && m_owner);
        chk32("rdata", rdata, m_rdata);
        if (t_m == 1) begin
            chk1("mem_we", mem_we, m_we);
            chk32("mem_addr", mem_addr, m_addr);
            if (m_we) chk32("mem_wdata", mem_wdata, m_wdata);
        end
        data_now = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            data_now = (rd_cnt == 0);
        end
        mem_rdata = data_now ? rd_val : $urandom;
        if (mem_en) begin
            if (mem_we) begin
                drv_mem[mem_addr[4:0]] = mem_wdata;
            end else begin
                rd_cnt = LAT;
                rd_val = drv_mem[mem_addr[4:0]];
            end
        end
    end

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            drv_mem[i] = 32'h5A00_0000 | 32'(i);
            mdl_mem[i] = 32'h5A00_0000 | 32'(i);
        end
        drv_mem[16] = 32'hDEAD_BEEF;
        mdl_mem[16] = 32'hDEAD_BEEF;

        repeat (2) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_cpu_ack", cpu_ack, 1'b0);
        chk1("rst_ldr_ack", ldr_ack, 1'b0);
        chk32("rst_rdata", rdata, 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_lat1_busy", s_busy, 1'b0);
        rst = 1'b0;

        // CPU read of 0x10 on both latencies
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        s_cpu_req = 1'b1; s_mem_rdata = $urandom;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            s_mem_rdata = (k == 2) ? 32'hA5A5_0001 : $urandom;
            if (k == 1) begin
                chk1("t1_mem_en_c1", mem_en, 1'b1);
                chk32("t1_mem_addr", mem_addr, 32'h10);
                chk1("lat1_mem_en_c1", s_mem_en, 1'b1);
            end
            if (k == 2) begin
                chk1("t1_mem_en_c2", mem_en, 1'b0);
                chk1("lat1_ack_c2", s_cpu_ack, 1'b0);
            end
            if (k == 3) begin
                chk1("lat1_ack_c3", s_cpu_ack, 1'b1);
                chk32("lat1_rdata", s_rdata, 32'hA5A5_0001);
                chk1("t1_ack_c3", cpu_ack, 1'b0);
                s_cpu_req = 1'b0;
            end
            if (k == 4) begin
                chk1("t1_cpu_ack_c4", cpu_ack, 1'b1);
                chk32("t1_rdata", rdata, 32'hDEAD_BEEF);
                chk1("t1_ldr_ack", ldr_ack, 1'b0);
                cpu_req = 1'b0;
            end
        end

        // Loader write then CPU read-back
        @(negedge clk);
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h4; ldr_wdata = 32'h1234_5678;
        for (int k = 1; k <= LAT + 2; k++) @(negedge clk);
        chk1("t2_ldr_ack", ldr_ack, 1'b1);
        chk32("t2_rdata_hold", rdata, 32'hDEAD_BEEF);
        ldr_req = 1'b0; ldr_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
        for (int k = 1; k <= LAT + 3; k++) @(negedge clk);
        chk1("t2_cpu_ack", cpu_ack, 1'b1);
        chk32("t2_rdata", rdata, 32'h1234_5678);
        cpu_req = 1'b0;

        // Round-robin with both requests held
        @(negedge clk);
        pulse_reset();
        cpu_req = 1'b1; ldr_req = 1'b1; cpu_we = 1'b0; ldr_we = 1'b0; ldr_addr = 32'h10;
        for (int k = 1; k <= 4 * P; k++) begin
            @(negedge clk);
            chk1("rr_cpu_ack", cpu_ack, (k % P == P - 1) && ((k / P) % 2 == 0));
            chk1("rr_ldr_ack", ldr_ack, (k % P == P - 1) && ((k / P) % 2 == 1));
        end
        cpu_req = 1'b0; ldr_req = 1'b0;

        // Loader lock, then release
        @(negedge clk);
        ldr_lock = 1'b1; cpu_req = 1'b1; ldr_req = 1'b1;
        for (int k = 1; k <= 4 * P + LAT + 2; k++) begin
            @(negedge clk);
            chk1("lock_ldr_ack", ldr_ack, (k % P == P - 1) && (k < 4 * P));
            chk1("lock_cpu_ack", cpu_ack, k == 4 * P + LAT + 2);
            if (k == 4 * P - 1) ldr_lock = 1'b0;
        end
        cpu_req = 1'b0; ldr_req = 1'b0;

        // Reset during WAIT of a CPU read
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_mem_en", mem_en, 1'b0);
        chk1("mid_rst_cpu_ack", cpu_ack, 1'b0);
        chk32("mid_rst_rdata", rdata, 32'h0);
        chk32("mid_rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        chk1("mid_rst_no_ack", cpu_ack, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            chk1("post_rst_ack", cpu_ack, k == LAT + 2);
        end
        chk32("post_rst_rdata", rdata, 32'h1234_5678);
        cpu_req = 1'b0;

        // Randomized traffic, occasional lock and reset
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                #2;
                rst = 1'b1;
            end
            cpu_req   = ($urandom_range(0, 2) != 0);
            ldr_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            ldr_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 32'($urandom_range(0, 31));
            ldr_addr  = 32'($urandom_range(0, 31));
            cpu_wdata = $urandom;
            ldr_wdata = $urandom;
            ldr_lock  = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
        repeat (P + 2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
